// File: rtl/md_sched.sv
// Multiply/divide scheduler for the E stage: owns HI/LO, runs mult/div over a
// fixed countdown, supplies mfhi/mflo data and stalls HILO users in D.
module md_sched #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_E,
   input  logic [3:0]  md_op_E,
   input  logic [31:0] rs_E,
   input  logic [31:0] rt_E,
   input  logic        md_use_D,
   output logic        busy,
   output logic        stall_md,
   output logic [31:0] hilo_result,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] count;
   logic [31:0]   pend_hi, pend_lo;
   logic          pend_wr;
   logic          start_ok, commit;

   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic        [31:0] q_s, r_s, q_u, r_u;

   // start_E/md_op_E form a single-cycle request: it is taken at the edge it is
   // sampled only when the scheduler is IDLE; no acknowledge is returned.
   assign start_ok = (state == IDLE) && start_E &&
                     (md_op_E >= OP_MULT) && (md_op_E <= OP_DIVU);

   assign prod_s = $signed({{32{rs_E[31]}}, rs_E}) * $signed({{32{rt_E[31]}}, rt_E});
   assign prod_u = {32'b0, rs_E} * {32'b0, rt_E};

   // Division by zero yields don't-care values (HI/LO are not written); the
   // most-negative / -1 case is pinned so it never depends on operator overflow.
   always_comb begin
      q_s = '0;
      r_s = '0;
      q_u = '0;
      r_u = '0;
      if (rt_E != 32'd0) begin
         q_u = rs_E / rt_E;
         r_u = rs_E % rt_E;
         if (rs_E == 32'h8000_0000 && rt_E == 32'hFFFF_FFFF) begin
            q_s = 32'h8000_0000;
            r_s = 32'd0;
         end else begin
            q_s = $signed(rs_E) / $signed(rt_E);
            r_s = $signed(rs_E) % $signed(rt_E);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      commit    = 1'b0;
      case (state)
         IDLE: if (start_ok) state_nxt = BUSY;
         BUSY: begin
            if (count == CW'(1)) begin
               state_nxt = IDLE;
               commit    = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         count   <= '0;
         done    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_wr <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= commit;
         if (start_ok) begin
            count   <= (md_op_E >= OP_DIV) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            pend_wr <= 1'b1;
            case (md_op_E)
               OP_MULT:  {pend_hi, pend_lo} <= prod_s;
               OP_MULTU: {pend_hi, pend_lo} <= prod_u;
               OP_DIV: begin
                  pend_hi <= r_s;
                  pend_lo <= q_s;
                  pend_wr <= (rt_E != 32'd0);
               end
               default: begin
                  pend_hi <= r_u;
                  pend_lo <= q_u;
                  pend_wr <= (rt_E != 32'd0);
               end
            endcase
         end else if (state == BUSY) begin
            count <= count - CW'(1);
         end
         if (commit && pend_wr) begin
            hi <= pend_hi;
            lo <= pend_lo;
         end else if (state == IDLE) begin
            if (md_op_E == OP_MTHI) hi <= rs_E;
            if (md_op_E == OP_MTLO) lo <= rs_E;
         end
      end
   end

   assign busy     = (state == BUSY);
   assign stall_md = md_use_D & (busy | start_E);

   always_comb begin
      hilo_result = '0;
      if (md_op_E == OP_MFHI) hilo_result = hi;
      else if (md_op_E == OP_MFLO) hilo_result = lo;
   end

   // Hazard logic must hold HILO instructions in D while an operation is in flight.
   assert property (@(posedge clk) disable iff (reset)
      (state == BUSY) |-> !(start_E || md_op_E == OP_MTHI || md_op_E == OP_MTLO));

endmodule

// File: tb/tb_md_sched.sv
// Bench for md_sched: directed plan cases plus random mult/div traffic checked
// against a 64-bit arithmetic reference model through an expected-result queue.
module tb_md_sched;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_E;
   logic [3:0]  md_op_E;
   logic [31:0] rs_E, rt_E;
   logic        md_use_D;
   logic        busy, stall_md, done;
   logic [31:0] hilo_result, hi, lo;

   int          checks = 0;
   int          failures = 0;
   int          done_seen = 0;
   logic [63:0] exp_q[$];
   logic [63:0] mon_exp;
   logic [31:0] m_hi, m_lo;

   md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .start_E(start_E), .md_op_E(md_op_E),
      .rs_E(rs_E), .rt_E(rt_E), .md_use_D(md_use_D), .busy(busy),
      .stall_md(stall_md), .hilo_result(hilo_result), .done(done),
      .hi(hi), .lo(lo)
   );

   // clock
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // reference model: architectural result {hi,lo} from plain 64-bit arithmetic
   function automatic logic [63:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] cur);
      longint          sa, sb, q, r;
      longint unsigned ua, ub, uq, ur;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'b0, a};
      ub = {32'b0, b};
      ref_op = cur;
      case (op)
         4'd1: ref_op = sa * sb;
         4'd2: ref_op = ua * ub;
         4'd3: if (b != 0) begin
            q = sa / sb;
            r = sa % sb;
            ref_op = {r[31:0], q[31:0]};
         end
         4'd4: if (b != 0) begin
            uq = ua / ub;
            ur = ua % ub;
            ref_op = {ur[31:0], uq[31:0]};
         end
         default: ref_op = cur;
      endcase
   endfunction

   // scoreboard monitor: every done pulse must match the oldest expected result
   always @(negedge clk) begin
      if (!reset && done === 1'b1) begin
         done_seen++;
         if (exp_q.size() == 0) begin
            check("spurious_done", 64'(exp_q.size()), 64'd1);
         end else begin
            mon_exp = exp_q.pop_front();
            check("commit_hilo", {hi, lo}, mon_exp);
         end
      end
   end

   task automatic wait_idle();
      int t = 0;
      @(posedge clk); #1;
      while (busy && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (busy) check("idle_timeout", busy, 0);
   endtask

   task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d);
      int n = (op >= 4'd3) ? DC : MC;
      int d0;
      logic [63:0] e;
      wait_idle();
      start_E = 1'b1; md_op_E = op; rs_E = a; rt_E = b; md_use_D = use_d;
      #1 check("stall_start", stall_md, use_d);
      e = ref_op(op, a, b, {m_hi, m_lo});
      exp_q.push_back(e);
      m_hi = e[63:32];
      m_lo = e[31:0];
      d0 = done_seen;
      @(posedge clk); #1;
      start_E = 1'b0; md_op_E = 4'd0; rs_E = $urandom; rt_E = $urandom;
      for (int i = 0; i < n; i++) begin
         check("busy_during", busy, 1);
         check("stall_during", stall_md, use_d);
         @(posedge clk); #1;
      end
      check("busy_after", busy, 0);
      check("stall_after", stall_md, 0);
      check("hi_after", hi, m_hi);
      check("lo_after", lo, m_lo);
      @(negedge clk); #1;
      check("done_count", 64'(done_seen - d0), 64'd1);
      md_use_D = 1'b0;
   endtask

   task automatic mt(input logic [3:0] op, input logic [31:0] v);
      wait_idle();
      md_op_E = op; rs_E = v;
      @(posedge clk); #1;
      md_op_E = 4'd0;
      if (op == 4'd7) m_hi = v; else m_lo = v;
      check("mt_hi", hi, m_hi);
      check("mt_lo", lo, m_lo);
   endtask

   task automatic mf();
      wait_idle();
      md_use_D = 1'b1;
      md_op_E = 4'd5;
      #1 check("mfhi", hilo_result, m_hi);
      check("stall_idle", stall_md, 0);
      md_op_E = 4'd6;
      #1 check("mflo", hilo_result, m_lo);
      md_op_E = 4'd0;
      #1 check("mf_none", hilo_result, 0);
      md_use_D = 1'b0;
   endtask

   // driver
   initial begin
      logic [3:0]  op;
      logic [31:0] a, b;
      int          sel;
      reset = 1'b1; start_E = 1'b0; md_op_E = 4'd0; rs_E = '0; rt_E = '0; md_use_D = 1'b0;
      m_hi = '0; m_lo = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", hilo_result, 0);
      reset = 1'b0;

      // reset abandons an in-flight multiply
      mt(4'd7, 32'h55);
      mt(4'd8, 32'h66);
      wait_idle();
      start_E = 1'b1; md_op_E = 4'd1; rs_E = 32'd7; rt_E = 32'd6;
      @(posedge clk); #1;
      start_E = 1'b0; md_op_E = 4'd0;
      @(posedge clk); #1;
      check("rst_mid_busy_pre", busy, 1);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_hi", hi, 0);
      check("rst_mid_lo", lo, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_done", done, 0);
      m_hi = '0; m_lo = '0;
      @(posedge clk); #1 reset = 1'b0;
      repeat (12) @(posedge clk);

      // directed plan cases
      do_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1);
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFFA);
      do_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      check("multu_hi", hi, 32'hFFFF_FFFE);
      check("multu_lo", lo, 32'h0000_0001);
      do_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
      check("div_hi", hi, 32'hFFFF_FFFF);
      check("div_lo", lo, 32'hFFFF_FFFD);
      mt(4'd7, 32'h11);
      mt(4'd8, 32'h22);
      do_op(4'd3, 32'd1234, 32'd0, 1'b1);
      check("div0_hi", hi, 32'h11);
      check("div0_lo", lo, 32'h22);
      do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check("ovf_lo", lo, 32'h8000_0000);
      check("ovf_hi", hi, 32'h0);
      mt(4'd7, 32'hABCD);
      mf();

      // start with a non-mult/div op is ignored
      wait_idle();
      start_E = 1'b1; md_op_E = 4'd9;
      @(posedge clk); #1;
      start_E = 1'b0; md_op_E = 4'd0;
      check("bad_start_busy", busy, 0);
      check("bad_start_hi", hi, m_hi);

      // random traffic
      for (int i = 0; i < 30; i++) begin
         sel = $urandom_range(0, 9);
         if (sel < 2) begin
            mt(($urandom_range(0, 1) == 0) ? 4'd7 : 4'd8, $urandom);
         end else if (sel == 2) begin
            mf();
         end else begin
            op = 4'($urandom_range(1, 4));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
               0: b = 32'd0;
               1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
               2: b = 32'($urandom_range(1, 9));
               default: ;
            endcase
            do_op(op, a, b, 1'($urandom_range(0, 1)));
         end
      end

      repeat (4) @(posedge clk);
      #1 check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
